// File: rtl/jpeg_ycc_pkg.sv
// rtl/jpeg_ycc_pkg.sv - shared coefficients, offsets and pixel type for RGB to YCbCr conversion
package jpeg_ycc_pkg;

   localparam int YCC_FRAC = 16;
   localparam int SUM_W    = 26;

   typedef logic signed [SUM_W-1:0] sum_t;

   // JFIF Q16 coefficients, row = output component, column = R, G, B
   localparam sum_t C_Y_R  =  26'sd19595;
   localparam sum_t C_Y_G  =  26'sd38470;
   localparam sum_t C_Y_B  =  26'sd7471;
   localparam sum_t C_CB_R = -26'sd11059;
   localparam sum_t C_CB_G = -26'sd21709;
   localparam sum_t C_CB_B =  26'sd32768;
   localparam sum_t C_CR_R =  26'sd32768;
   localparam sum_t C_CR_G = -26'sd27439;
   localparam sum_t C_CR_B = -26'sd5329;

   typedef struct packed {
      logic [7:0] y;
      logic [7:0] cb;
      logic [7:0] cr;
   } ycc_pix_t;

   // Rounding offset for luma: half an LSB of the integer result
   function automatic sum_t ofs_y(input int frac);
      return sum_t'(1 << (frac - 1));
   endfunction

   // Chroma offset: re-centre to 128 plus rounding half LSB
   function automatic sum_t ofs_c(input int frac);
      return sum_t'((128 << frac) + (1 << (frac - 1)));
   endfunction

   localparam sum_t OFS_Y = ofs_y(YCC_FRAC);
   localparam sum_t OFS_C = ofs_c(YCC_FRAC);

   // Unsigned 8-bit sample times signed coefficient; true result always fits SUM_W
   function automatic sum_t mul8(input logic [7:0] v, input sum_t c);
      sum_t sv;
      sv = {{(SUM_W-8){1'b0}}, v};
      return sv * c;
   endfunction

endpackage

// File: rtl/rgb_to_ycc_if.sv
// rtl/rgb_to_ycc_if.sv - pixel-in / pixel-out handshake bundle for rgb_to_ycc
interface rgb_to_ycc_if;

   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_r;
   logic [7:0] in_g;
   logic [7:0] in_b;

   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_y;
   logic [7:0] out_cb;
   logic [7:0] out_cr;
   logic       out_last;

   modport slave (
      input  in_valid, in_r, in_g, in_b, out_ready,
      output in_ready, out_valid, out_y, out_cb, out_cr, out_last
   );

   modport master (
      output in_valid, in_r, in_g, in_b, out_ready,
      input  in_ready, out_valid, out_y, out_cb, out_cr, out_last
   );

endinterface

// File: rtl/ycc_clamp8.sv
// rtl/ycc_clamp8.sv - arithmetic shift of a fixed-point sum and saturation to 0..255
module ycc_clamp8 import jpeg_ycc_pkg::*; #(
   parameter int FRAC = YCC_FRAC
) (
   input  sum_t       sum,
   output logic [7:0] val
);

   sum_t shifted;

   // Negative results floor to 0, anything with bits above bit 7 saturates to 255
   always_comb begin
      shifted = sum >>> FRAC;
      if (shifted[SUM_W-1]) begin
         val = 8'd0;
      end else if (|shifted[SUM_W-2:8]) begin
         val = 8'd255;
      end else begin
         val = shifted[7:0];
      end
   end

endmodule

// File: rtl/rgb_to_ycc.sv
// rtl/rgb_to_ycc.sv - 3-stage RGB to JFIF YCbCr converter with MCU block last flag
module rgb_to_ycc import jpeg_ycc_pkg::*; #(
   parameter int BLOCK_PIX = 64,
   parameter int FRAC      = YCC_FRAC
) (
   input logic         clk,
   input logic         rst,
   rgb_to_ycc_if.slave bus
);

   localparam int   CNT_W  = $clog2(BLOCK_PIX);
   localparam sum_t OFS_YV = ofs_y(FRAC);
   localparam sum_t OFS_CV = ofs_c(FRAC);

   logic             advance;
   logic             accept;
   logic [CNT_W-1:0] pix_cnt;
   logic             cnt_wrap;

   logic v1, v2, v3;
   logic l1, l2, l3;

   sum_t p_yr, p_yg, p_yb;
   sum_t p_cbr, p_cbg, p_cbb;
   sum_t p_crr, p_crg, p_crb;
   sum_t s_y, s_cb, s_cr;

   ycc_pix_t pix_c;
   ycc_pix_t pix3;

   // The whole pipeline moves together; it only freezes when the output is held
   assign advance      = !v3 || bus.out_ready;
   assign accept       = bus.in_valid && advance;
   assign cnt_wrap     = (pix_cnt == CNT_W'(BLOCK_PIX - 1));
   assign bus.in_ready = advance;

   // Position of the next accepted pixel within its MCU block
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt <= '0;
      end else if (accept) begin
         pix_cnt <= cnt_wrap ? '0 : pix_cnt + 1'b1;
      end
   end

   // Stage valid bits and the last flag riding alongside each pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
         l1 <= 1'b0;
         l2 <= 1'b0;
         l3 <= 1'b0;
      end else if (advance) begin
         v1 <= bus.in_valid;
         v2 <= v1;
         v3 <= v2;
         l1 <= bus.in_valid && cnt_wrap;
         l2 <= l1;
         l3 <= l2;
      end
   end

   // S1: the nine coefficient products
   always_ff @(posedge clk) begin
      if (advance) begin
         p_yr  <= mul8(bus.in_r, C_Y_R);
         p_yg  <= mul8(bus.in_g, C_Y_G);
         p_yb  <= mul8(bus.in_b, C_Y_B);
         p_cbr <= mul8(bus.in_r, C_CB_R);
         p_cbg <= mul8(bus.in_g, C_CB_G);
         p_cbb <= mul8(bus.in_b, C_CB_B);
         p_crr <= mul8(bus.in_r, C_CR_R);
         p_crg <= mul8(bus.in_g, C_CR_G);
         p_crb <= mul8(bus.in_b, C_CR_B);
      end
   end

   // S2: three-term sums with rounding and chroma re-centring offsets
   always_ff @(posedge clk) begin
      if (advance) begin
         s_y  <= p_yr  + p_yg  + p_yb  + OFS_YV;
         s_cb <= p_cbr + p_cbg + p_cbb + OFS_CV;
         s_cr <= p_crr + p_crg + p_crb + OFS_CV;
      end
   end

   ycc_clamp8 #(.FRAC(FRAC)) u_clamp_y  (.sum(s_y),  .val(pix_c.y));
   ycc_clamp8 #(.FRAC(FRAC)) u_clamp_cb (.sum(s_cb), .val(pix_c.cb));
   ycc_clamp8 #(.FRAC(FRAC)) u_clamp_cr (.sum(s_cr), .val(pix_c.cr));

   // S3: shifted and saturated output pixel, held while downstream stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         pix3 <= '0;
      end else if (advance) begin
         pix3 <= pix_c;
      end
   end

   assign bus.out_valid = v3;
   assign bus.out_y     = pix3.y;
   assign bus.out_cb    = pix3.cb;
   assign bus.out_cr    = pix3.cr;
   assign bus.out_last  = l3;

endmodule

// File: tb/tb_rgb_to_ycc.sv
// tb/tb_rgb_to_ycc.sv - scoreboard bench for rgb_to_ycc against an integer reference model
module tb_rgb_to_ycc;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rgb_to_ycc_if bus();

   rgb_to_ycc dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int y;
      int cb;
      int cr;
      bit last;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;
   int   pix_idx = 0;
   int   out_count = 0;
   int   last_count = 0;
   bit   rand_ready = 0;
   bit   sender_done = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int clamp255(input int v);
      return (v < 0) ? 0 : ((v > 255) ? 255 : v);
   endfunction

   function automatic exp_t model(input int r, input int g, input int b);
      exp_t e;
      e.y  = clamp255((19595 * r + 38470 * g + 7471 * b + 32768) >>> 16);
      e.cb = clamp255((-11059 * r - 21709 * g + 32768 * b + (128 << 16) + 32768) >>> 16);
      e.cr = clamp255((32768 * r - 27439 * g - 5329 * b + (128 << 16) + 32768) >>> 16);
      e.last = 1'b0;
      return e;
   endfunction

   // Present one pixel from a falling edge until accepted; queue its expected result
   task automatic send(input int r, input int g, input int b,
                       input bit use_lit, input int ly, input int lcb, input int lcr);
      exp_t e;
      int   waited = 0;
      bit   ok = 0;
      bus.in_valid = 1'b1;
      bus.in_r = 8'(r);
      bus.in_g = 8'(g);
      bus.in_b = 8'(b);
      while (!ok && waited < 300) begin
         #1;
         if (bus.in_ready) ok = 1;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      if (!ok) begin
         check("in_ready_timeout", 0, 1);
      end else begin
         e = model(r, g, b);
         if (use_lit) begin
            e.y  = ly;
            e.cb = lcb;
            e.cr = lcr;
         end
         e.last = (pix_idx == 63);
         pix_idx = (pix_idx + 1) % 64;
         sb.push_back(e);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic send_rand();
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 0, 0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", sb.size(), 0);
   endtask

   task automatic pulse_reset(input int cycles);
      rst = 1'b1;
      sb.delete();
      pix_idx = 0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every output transfer is compared with the oldest expected pixel
   always @(negedge clk) begin
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("out_y", bus.out_y, mon_e.y);
            check("out_cb", bus.out_cb, mon_e.cb);
            check("out_cr", bus.out_cr, mon_e.cr);
            check("out_last", bus.out_last, mon_e.last);
            out_count++;
            if (bus.out_last) last_count++;
         end
      end
   end

   // Downstream back-pressure generator, active only in the mixed phase
   initial begin
      forever begin
         @(negedge clk);
         if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      int lat;
      int base_out;
      int base_last;
      int cap_y, cap_cb, cap_cr, cap_l;
      int n;

      bus.in_valid  = 1'b0;
      bus.in_r      = 8'd0;
      bus.in_g      = 8'd0;
      bus.in_b      = 8'd0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_out_y", bus.out_y, 0);
      check("reset_out_cb", bus.out_cb, 0);
      check("reset_out_cr", bus.out_cr, 0);
      check("reset_out_last", bus.out_last, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Latency with white, then known colours back to back
      send(255, 255, 255, 1, 255, 128, 128);
      lat = 1;
      #1;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         #1;
         lat++;
      end
      check("latency_cycles", lat, 3);
      @(negedge clk);
      send(0, 0, 0, 1, 0, 128, 128);
      send(255, 0, 0, 1, 76, 85, 255);
      send(0, 0, 255, 1, 29, 255, 107);
      send(0, 255, 0, 1, 150, 44, 21);
      wait_drain();

      // 130-pixel stream from a freshly reset counter
      pulse_reset(1);
      base_out = out_count;
      base_last = last_count;
      for (int i = 0; i < 130; i++) send_rand();
      wait_drain();
      check("stream130_count", out_count - base_out, 130);
      check("stream130_lasts", last_count - base_last, 2);

      // Hold the output while ten pixels are offered
      base_out = out_count;
      bus.out_ready = 1'b0;
      sender_done = 0;
      fork
         begin
            for (int i = 0; i < 10; i++) send_rand();
            sender_done = 1;
         end
      join_none
      repeat (4) @(negedge clk);
      #3;
      check("stall_in_ready_low", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      cap_y = bus.out_y;
      cap_cb = bus.out_cb;
      cap_cr = bus.out_cr;
      cap_l = bus.out_last;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #3;
         check("stall_hold_y", bus.out_y, cap_y);
         check("stall_hold_cb", bus.out_cb, cap_cb);
         check("stall_hold_cr", bus.out_cr, cap_cr);
         check("stall_hold_last", bus.out_last, cap_l);
         check("stall_hold_in_ready", bus.in_ready, 0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      n = 0;
      while (!sender_done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("stall_sender_done", sender_done, 1);
      wait_drain();
      check("stall_count", out_count - base_out, 10);

      // Random input gaps and random downstream readiness
      base_out = out_count;
      rand_ready = 1;
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         send_rand();
      end
      rand_ready = 0;
      @(negedge clk);
      bus.out_ready = 1'b1;
      wait_drain();
      check("mixed_count", out_count - base_out, 100);

      // Reset with two pixels in flight, then a full block
      send_rand();
      send_rand();
      pulse_reset(1);
      #1;
      check("midreset_out_valid", bus.out_valid, 0);
      @(negedge clk);
      base_out = out_count;
      base_last = last_count;
      for (int i = 0; i < 64; i++) send_rand();
      wait_drain();
      check("post_reset_count", out_count - base_out, 64);
      check("post_reset_lasts", last_count - base_last, 1);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rgb_to_ycc.md
RGB_TO_YCC -- requirements
Module: rgb_to_ycc

Interface
REQ-001 Parameter BLOCK_PIX, default 64, number of pixels per 8x8 MCU block; sets the out_last period.
REQ-002 Parameter FRAC, default 16, number of fractional bits in the fixed-point coefficients.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  input pixel present.
REQ-006 in_ready  output  1  block accepts the pixel this cycle.
REQ-007 in_r, in_g, in_b  input  8 each  unsigned RGB samples.
REQ-008 out_valid  output  1  output pixel present.
REQ-009 out_ready  input  1  downstream accepts the pixel this cycle.
REQ-010 out_y, out_cb, out_cr  output  8 each  unsigned JFIF YCbCr samples.
REQ-011 out_last  output  1  high on the final pixel of each BLOCK_PIX-pixel block.

Function
REQ-012 A transfer occurs on a rising edge where valid and ready are both high; the in side and the out side follow this rule independently.
REQ-013 Pipeline: 3 stages with one valid bit per stage.
  - S1 registers the products.
  - S2 registers the three 3-term sums plus offsets.
  - S3 registers the shifted and clamped outputs.
REQ-014 Latency is exactly 3 cycles from input transfer to out_valid when out_ready is held high; throughput is 1 pixel per cycle.
REQ-015 Stall rule: advance = !S3.valid || out_ready; in_ready = advance; all stages shift only when advance is high; no pixel is dropped or duplicated.
REQ-016 Q16 coefficients (signed):
  - Y  = 19595, 38470, 7471
  - Cb = -11059, -21709, 32768
  - Cr = 32768, -27439, -5329
REQ-017 Offsets: Y adds 1<<(FRAC-1); Cb and Cr add (128<<FRAC) + (1<<(FRAC-1)).
REQ-018 Sums are 26-bit signed; result = sum >>> FRAC (arithmetic shift); the result is clamped to 0..255.
REQ-019 While out_valid is high and out_ready is low, out_y, out_cb, out_cr and out_last stay stable.
REQ-020 A 6-bit pixel counter (log2 BLOCK_PIX) increments on each input transfer and wraps from BLOCK_PIX-1 to 0; it travels down the pipeline as a last flag set when count == BLOCK_PIX-1.
REQ-021 When in_valid and out_ready are both high with a full pipeline, one pixel is accepted and one is emitted in the same cycle.

Reset
REQ-022 While rst is high at a clock edge:
  - all stage valid bits clear, so out_valid = 0;
  - the pixel counter is 0;
  - out_y, out_cb, out_cr = 0 and out_last = 0;
  - in_ready = 1.
REQ-023 Reset mid-stream discards all in-flight pixels; the first pixel after reset is counted as index 0.

Structure
REQ-024 A shared package jpeg_ycc_pkg holds:
  - the nine coefficient constants;
  - FRAC and the offset constants;
  - a pixel struct type {y, cb, cr}.
REQ-025 One sub-module, ycc_clamp8, performs the shift and 0..255 saturation; it is instantiated 3 times in S3.

Verification
REQ-026 White (255,255,255), out_ready=1 -> after 3 cycles (255,128,128); black (0,0,0) -> (0,128,128).
REQ-027 Red (255,0,0) -> (76,85,255), with Cr saturated from 256; blue (0,0,255) -> (29,255,107); green (0,255,0) -> (150,44,21).
REQ-028 Stream 130 random pixels with out_ready=1 -> out_last on output pixels 63 and 127 only; all outputs match the Q16 golden model.
REQ-029 Feed 10 pixels and hold out_ready=0 for 5 cycles -> in_ready drops after the pipeline fills and the held output is stable; on release all 10 pixels emerge in order with no loss.
REQ-030 Assert rst for 1 cycle with 2 pixels in flight -> out_valid=0 next cycle; a 64-pixel stream fed afterwards puts out_last on its 64th pixel.
